sensor_calc_seq: RTL



---
 rtl/sensor_calc_seq_if.sv | 23 ++
 rtl/sensor_calc_seq.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/sensor_calc_seq_if.sv
// Handshake and result bundle between the SHT30 reader, sensor_calc_seq and the segment scanner.
interface sensor_calc_seq_if;
    logic        start;
    logic [15:0] T_code;
    logic [15:0] H_code;
    logic        busy;
    logic        done;
    logic        t_neg;
    logic [15:0] T_data;
    logic [15:0] H_data;
    logic [7:0]  dat_en;
    logic [7:0]  dot_en;

    modport master (
        output start, T_code, H_code,
        input  busy, done, t_neg, T_data, H_data, dat_en, dot_en
    );

    modport slave (
        input  start, T_code, H_code,
        output busy, done, t_neg, T_data, H_data, dat_en, dot_en
    );
endinterface

// File: rtl/sensor_calc_seq.sv
// Sequential temperature/humidity scaler with one shared shift-per-cycle double-dabble BCD engine.
// Optional macro CALC_FAHRENHEIT_EN switches the temperature path to 0.01 degF span/offset.
module sensor_calc_seq #(
    parameter int unsigned T_SCALE    = 17500,
    parameter int unsigned T_OFFSET   = 4500,
    parameter int unsigned H_SCALE    = 1000,
    parameter int unsigned BCD_DIGITS = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    sensor_calc_seq_if.slave bus
);

    if (BCD_DIGITS != 5) begin : g_bad_digits
        $error("sensor_calc_seq: BCD_DIGITS must be 5 for 16-bit inputs");
    end

`ifdef CALC_FAHRENHEIT_EN
    localparam int unsigned T_SPAN = 31500;
    localparam int unsigned T_OFF  = 4900;
`else
    localparam int unsigned T_SPAN = T_SCALE;
    localparam int unsigned T_OFF  = T_OFFSET;
`endif

    typedef enum logic [2:0] {IDLE, CALC_T, BCD_T, CALC_H, BCD_H, OUT} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q;
    logic [15:0] t_code_q, h_code_q;
    logic [15:0] bin_q;
    logic [19:0] bcd_q;
    logic [19:0] bcd_adj;
    logic [15:0] t_bcd_q;
    logic        neg_q;

    logic [31:0] t_prod, h_prod;
    logic [15:0] t_b, t_mag_raw, t_mag, h_e;
    logic        t_neg_c;
    logic [15:0] t_data_c, h_data_c;
    logic [7:0]  dat_en_c;

    logic        done_q, t_neg_q;
    logic [15:0] t_data_q, h_data_q;
    logic [7:0]  dat_en_q, dot_en_q;

    function automatic logic [19:0] dd_adjust(input logic [19:0] v);
        logic [19:0] r;
        r = v;
        for (int unsigned i = 0; i < 5; i++) begin
            if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    always_comb begin
        t_prod    = 32'(t_code_q) * 32'(T_SPAN);
        h_prod    = 32'(h_code_q) * 32'(H_SCALE);
        t_b       = 16'(t_prod >> 16);
        h_e       = 16'(h_prod >> 16);
        t_neg_c   = (t_b < 16'(T_OFF));
        t_mag_raw = t_neg_c ? (16'(T_OFF) - t_b) : (t_b - 16'(T_OFF));
        t_mag     = (t_neg_c && (t_mag_raw > 16'd9999)) ? 16'd9999 : t_mag_raw;
        bcd_adj   = dd_adjust(bcd_q);
    end

    // t_bcd_q holds temperature BCD[19:4]; the hundredths digit is never displayed
    always_comb begin
        t_data_c      = neg_q ? {4'hA, t_bcd_q[11:0]} : t_bcd_q;
        h_data_c      = bcd_q[15:0];
        dat_en_c      = 8'h33;
        dat_en_c[7]   = |t_data_c[15:12];
        dat_en_c[6]   = neg_q ? |t_data_c[11:8] : |t_data_c[15:8];
        dat_en_c[3]   = |h_data_c[15:12];
        dat_en_c[2]   = |h_data_c[15:8];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = CALC_T;
            CALC_T:  state_d = BCD_T;
            BCD_T:   if (cnt_q == 4'd15) state_d = CALC_H;
            CALC_H:  state_d = BCD_H;
            BCD_H:   if (cnt_q == 4'd15) state_d = OUT;
            OUT:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            t_code_q <= '0;
            h_code_q <= '0;
            bin_q    <= '0;
            bcd_q    <= '0;
            t_bcd_q  <= '0;
            neg_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        t_code_q <= bus.T_code;
                        h_code_q <= bus.H_code;
                    end
                end
                CALC_T: begin
                    bin_q <= t_mag;
                    bcd_q <= '0;
                    cnt_q <= '0;
                    neg_q <= t_neg_c;
                end
                BCD_T, BCD_H: begin
                    bcd_q <= {bcd_adj[18:0], bin_q[15]};
                    bin_q <= {bin_q[14:0], 1'b0};
                    cnt_q <= cnt_q + 4'd1;
                end
                CALC_H: begin
                    t_bcd_q <= bcd_q[19:4];
                    bin_q   <= h_e;
                    bcd_q   <= '0;
                    cnt_q   <= '0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q   <= 1'b0;
            t_neg_q  <= 1'b0;
            t_data_q <= '0;
            h_data_q <= '0;
            dat_en_q <= 8'h33;
            dot_en_q <= 8'h22;
        end else begin
            done_q <= (state_q == OUT);
            if (state_q == OUT) begin
                t_neg_q  <= neg_q;
                t_data_q <= t_data_c;
                h_data_q <= h_data_c;
                dat_en_q <= dat_en_c;
                dot_en_q <= 8'h22;
            end
        end
    end

    assign bus.busy   = (state_q != IDLE);
    assign bus.done   = done_q;
    assign bus.t_neg  = t_neg_q;
    assign bus.T_data = t_data_q;
    assign bus.H_data = h_data_q;
    assign bus.dat_en = dat_en_q;
    assign bus.dot_en = dot_en_q;

endmodule
